// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low glyph table {g,f,e,d,c,b,a}, digit count
// and the scan-decoder FSM states. The display encoder uses the same table.
package seg7_pkg;

  localparam int NUM_DIGITS = 3;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Entry i is the glyph for nibble i.
  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
    SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_COMPLETE
  } state_e;

endpackage

// File: rtl/seg7_pattern_decoder.sv
// Inverse of the display glyph table: active-low pattern to hex nibble.
// Unknown patterns, including blank, give nibble 0 with ok low.
module seg7_pattern_decoder
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       ok
);

  always_comb begin
    // NOTE: defaults first, so every path assigns both outputs and no latch is inferred.
    nibble = 4'h0;
    ok     = 1'b0;
    if (pattern != SEG_BLANK) begin
      for (int i = 0; i < 16; i++) begin
        if (pattern == SEG_TABLE[i]) begin
          nibble = 4'(i);
          ok     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Samples a multiplexed active-low 3-digit 7-segment bus, decodes each settled digit
// and republishes the 12-bit value with frame error, stability and timeout status.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [6:0]                seg_n,
  input  logic [NUM_DIGITS-1:0]     an,
  output logic [4*NUM_DIGITS-1:0]   value,
  output logic                      value_valid,
  output logic                      frame_err,
  output logic                      stable,
  output logic                      timeout
);

  localparam int DWELL_W = $clog2(SETTLE_CYCLES) + 1;
  localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [NUM_DIGITS-1:0] MASK_FULL = '1;

  logic [6:0]            seg_s1_q, seg_s2_q;
  logic [NUM_DIGITS-1:0] an_s1_q, an_s2_q, an_prev_q;

  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  state_e             state_q, state_d;

  logic [NUM_DIGITS-1:0]       mask_q, mask_d;
  logic                        err_q, err_d;
  logic [NUM_DIGITS-1:0][3:0]  slot_q, slot_d;
  logic                        prev_valid_q, prev_valid_d;

  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic value_valid_q, value_valid_d;
  logic frame_err_q, frame_err_d;
  logic stable_q, stable_d;
  logic timeout_q, timeout_d;

  logic [3:0] dec_nibble;
  logic       dec_ok;
  logic       an_changed, an_onehot, an_multi, capture, restart;

  seg7_pattern_decoder u_decoder (
    .pattern (seg_s2_q),
    .nibble  (dec_nibble),
    .ok      (dec_ok)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_s1_q  <= '0;
      seg_s2_q  <= '0;
      an_s1_q   <= '0;
      an_s2_q   <= '0;
      an_prev_q <= '0;
    end else begin
      seg_s1_q  <= seg_n;
      seg_s2_q  <= seg_s1_q;
      an_s1_q   <= an;
      an_s2_q   <= an_s1_q;
      an_prev_q <= an_s2_q;
    end
  end

  assign an_changed = (an_s2_q != an_prev_q);
  assign an_onehot  = $onehot(an_s2_q);
  assign an_multi   = (an_s2_q != '0) && !an_onehot;

  // The change cycle counts as the first held cycle, so capture fires when the
  // counter shows SETTLE_CYCLES-2; it then parks one higher until the next change.
  assign capture = an_onehot && !an_changed && (dwell_q == DWELL_W'(SETTLE_CYCLES - 2));
  assign restart = capture && ((mask_q & an_s2_q) != '0);

  always_comb begin
    dwell_d = dwell_q;
    if (an_changed) begin
      dwell_d = '0;
    end else if (an_onehot && (dwell_q < DWELL_W'(SETTLE_CYCLES - 1))) begin
      dwell_d = dwell_q + DWELL_W'(1);
    end
  end

  always_comb begin
    state_d       = state_q;
    mask_d        = mask_q;
    err_d         = err_q;
    slot_d        = slot_q;
    to_cnt_d      = to_cnt_q;
    prev_valid_d  = prev_valid_q;
    value_d       = value_q;
    value_valid_d = 1'b0;
    frame_err_d   = frame_err_q;
    stable_d      = stable_q;
    timeout_d     = 1'b0;

    if (an_multi) err_d = 1'b1;

    if (capture) begin
      to_cnt_d = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (an_s2_q[k]) slot_d[k] = dec_nibble;
      end
      if (restart) begin
        mask_d = an_s2_q;
        err_d  = !dec_ok;
      end else begin
        mask_d = mask_q | an_s2_q;
        err_d  = err_q | !dec_ok;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (capture) state_d = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (capture) begin
          if (mask_d == MASK_FULL) state_d = ST_COMPLETE;
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          mask_d    = '0;
          err_d     = 1'b0;
          to_cnt_d  = '0;
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_COMPLETE: begin
        value_d       = slot_q;
        frame_err_d   = err_q;
        value_valid_d = 1'b1;
        stable_d      = prev_valid_q && !err_q && !frame_err_q && (slot_q == value_q);
        prev_valid_d  = 1'b1;
        mask_d        = '0;
        err_d         = an_multi;
        to_cnt_d      = '0;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the digit slots are a few flops, so they are reset with everything else;
      // a RAM-sized store would be left unreset and qualified by the mask instead.
      state_q       <= ST_IDLE;
      dwell_q       <= '0;
      to_cnt_q      <= '0;
      mask_q        <= '0;
      err_q         <= 1'b0;
      slot_q        <= '0;
      prev_valid_q  <= 1'b0;
      value_q       <= '0;
      value_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      stable_q      <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      dwell_q       <= dwell_d;
      to_cnt_q      <= to_cnt_d;
      mask_q        <= mask_d;
      err_q         <= err_d;
      slot_q        <= slot_d;
      prev_valid_q  <= prev_valid_d;
      value_q       <= value_d;
      value_valid_q <= value_valid_d;
      frame_err_q   <= frame_err_d;
      stable_q      <= stable_d;
      timeout_q     <= timeout_d;
    end
  end

  assign value       = value_q;
  assign value_valid = value_valid_q;
  assign frame_err   = frame_err_q;
  assign stable      = stable_q;
  assign timeout     = timeout_q;

endmodule
